// File: rtl/window_addr_gen_pkg.sv
// Shared types for the convolution window address generator.
// Holds the sweep FSM states, the latched layer config and the done pulse length.
package window_addr_gen_pkg;

    localparam int ADDR_W   = 8;
    localparam int DIM_W    = 8;
    localparam int K_W      = 4;
    localparam int CH_W     = 4;
    localparam int DONE_LEN = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [DIM_W-1:0]  i_size;
        logic [DIM_W-1:0]  o_size;
        logic [K_W-1:0]    k_size;
        logic [K_W-1:0]    stride;
        logic [CH_W-1:0]   channels;
        logic [ADDR_W-1:0] ch_stride;
    } cfg_t;

endpackage

// File: rtl/wag_loop_cnt.sv
// One level of the sweep loop nest: counts 0..limit-1 on i_inc.
// o_wrap fires on the increment that returns the count to zero.
module wag_loop_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_wrap
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    assign o_last = (cnt_q == i_limit - W'(1));
    assign o_wrap = i_inc & o_last;
    assign o_cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = o_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// Sweeps every output pixel and streams the KxKxC window read addresses.
// Define WINDOW_ADDR_GEN_STALL_CNT_EN to add the saturating o_stall_cnt port.
module window_addr_gen
    import window_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DIM_WIDTH  = DIM_W,
    parameter int K_WIDTH    = K_W,
    parameter int CH_WIDTH   = CH_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [DIM_WIDTH-1:0]  i_i_size,
    input  logic [DIM_WIDTH-1:0]  i_o_size,
    input  logic [K_WIDTH-1:0]    i_k_size,
    input  logic [K_WIDTH-1:0]    i_stride,
    input  logic [CH_WIDTH-1:0]   i_channels,
    input  logic [ADDR_WIDTH-1:0] i_ch_stride,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_valid,
    output logic                  o_last_win,
    output logic [DIM_WIDTH-1:0]  o_o_x,
    output logic [DIM_WIDTH-1:0]  o_o_y,
    output logic                  o_busy,
    output logic                  o_done
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    ,
    output logic [31:0]           o_stall_cnt
`endif
);

    state_t state_d, state_q;
    cfg_t   cfg_d, cfg_q;
    logic [ADDR_WIDTH-1:0] step_d, step_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [ADDR_WIDTH-1:0] row_d, row_q;
    logic [ADDR_WIDTH-1:0] chb_d, chb_q;
    logic [ADDR_WIDTH-1:0] win_d, win_q;
    logic [ADDR_WIDTH-1:0] line_d, line_q;
    logic valid_d, valid_q;
    logic busy_d, busy_q;
    logic done_d, done_q;
    logic [3:0] dcnt_d, dcnt_q;

    logic xfer, start_acc, degen;
    logic kx_last, ky_last, c_last, ox_last, oy_last;
    logic kx_wrap, ky_wrap, c_wrap, ox_wrap, oy_wrap;
    logic [K_WIDTH-1:0]  kx_cnt, ky_cnt;
    logic [CH_WIDTH-1:0] c_cnt;
    logic unused_cnt;

    assign xfer      = valid_q & i_ready & i_en;
    assign start_acc = i_en & i_start & (state_q == IDLE);
    assign degen     = (i_k_size == '0) | (i_stride == '0)
                     | (i_o_size == '0) | (i_channels == '0);

    // Innermost first; each level steps when the one inside it wraps.
    wag_loop_cnt #(.W(K_WIDTH)) u_kx (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(start_acc), .i_inc(xfer),
        .i_limit(cfg_q.k_size), .o_cnt(kx_cnt), .o_last(kx_last), .o_wrap(kx_wrap)
    );
    wag_loop_cnt #(.W(K_WIDTH)) u_ky (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(start_acc), .i_inc(kx_wrap),
        .i_limit(cfg_q.k_size), .o_cnt(ky_cnt), .o_last(ky_last), .o_wrap(ky_wrap)
    );
    wag_loop_cnt #(.W(CH_WIDTH)) u_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(start_acc), .i_inc(ky_wrap),
        .i_limit(cfg_q.channels), .o_cnt(c_cnt), .o_last(c_last), .o_wrap(c_wrap)
    );
    wag_loop_cnt #(.W(DIM_WIDTH)) u_ox (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(start_acc), .i_inc(c_wrap),
        .i_limit(cfg_q.o_size), .o_cnt(o_o_x), .o_last(ox_last), .o_wrap(ox_wrap)
    );
    wag_loop_cnt #(.W(DIM_WIDTH)) u_oy (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(start_acc), .i_inc(ox_wrap),
        .i_limit(cfg_q.o_size), .o_cnt(o_o_y), .o_last(oy_last), .o_wrap(oy_wrap)
    );

    assign unused_cnt = ^{kx_cnt, ky_cnt, c_cnt, ox_last, oy_last};

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        step_d  = step_q;
        addr_d  = addr_q;
        row_d   = row_q;
        chb_d   = chb_q;
        win_d   = win_q;
        line_d  = line_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        dcnt_d  = dcnt_q;
        if (i_en) begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cfg_d.base      = i_base_addr;
                        cfg_d.i_size    = i_i_size;
                        cfg_d.o_size    = i_o_size;
                        cfg_d.k_size    = i_k_size;
                        cfg_d.stride    = i_stride;
                        cfg_d.channels  = i_channels;
                        cfg_d.ch_stride = i_ch_stride;
                        // Row-of-windows step, formed once per sweep.
                        step_d = ADDR_WIDTH'(i_stride) * ADDR_WIDTH'(i_i_size);
                        dcnt_d = '0;
                        if (degen) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!valid_q) begin
                        valid_d = 1'b1;
                        addr_d  = cfg_q.base;
                        row_d   = cfg_q.base;
                        chb_d   = cfg_q.base;
                        win_d   = cfg_q.base;
                        line_d  = cfg_q.base;
                    end else if (xfer) begin
                        if (oy_wrap) begin
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            dcnt_d  = '0;
                            state_d = DONE;
                        end else if (ox_wrap) begin
                            line_d = line_q + step_q;
                            win_d  = line_d;
                            chb_d  = line_d;
                            row_d  = line_d;
                            addr_d = line_d;
                        end else if (c_wrap) begin
                            win_d  = win_q + ADDR_WIDTH'(cfg_q.stride);
                            chb_d  = win_d;
                            row_d  = win_d;
                            addr_d = win_d;
                        end else if (ky_wrap) begin
                            chb_d  = chb_q + cfg_q.ch_stride;
                            row_d  = chb_d;
                            addr_d = chb_d;
                        end else if (kx_wrap) begin
                            row_d  = row_q + ADDR_WIDTH'(cfg_q.i_size);
                            addr_d = row_d;
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    dcnt_d = dcnt_q + 4'd1;
                    if (dcnt_q == 4'(DONE_LEN - 1)) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            step_q  <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            chb_q   <= '0;
            win_q   <= '0;
            line_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            step_q  <= step_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            chb_q   <= chb_d;
            win_q   <= win_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_valid    = valid_q;
    assign o_last_win = valid_q & kx_last & ky_last & c_last;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    logic [31:0] stall_d, stall_q;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (valid_q && !i_ready && i_en && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_window_addr_gen.sv
// Scoreboard bench for window_addr_gen: a reference loop nest predicts each beat.
// Honours WINDOW_ADDR_GEN_STALL_CNT_EN when the design is built with it.
module tb_window_addr_gen;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int KW = 4;
    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst, i_en, i_start, i_ready;
    logic [AW-1:0] i_base_addr, i_ch_stride;
    logic [DW-1:0] i_i_size, i_o_size;
    logic [KW-1:0] i_k_size, i_stride;
    logic [CW-1:0] i_channels;
    logic [AW-1:0] o_addr;
    logic          o_valid, o_last_win, o_busy, o_done;
    logic [DW-1:0] o_o_x, o_o_y;
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
    logic [31:0]   o_stall_cnt;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
        logic [DW-1:0] ox;
        logic [DW-1:0] oy;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stall_cyc = 0;
    int valid_cnt = 0;

    window_addr_gen dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_i_size(i_i_size), .i_o_size(i_o_size),
        .i_k_size(i_k_size), .i_stride(i_stride), .i_channels(i_channels),
        .i_ch_stride(i_ch_stride), .i_ready(i_ready),
        .o_addr(o_addr), .o_valid(o_valid), .o_last_win(o_last_win),
        .o_o_x(o_o_x), .o_o_y(o_o_y), .o_busy(o_busy), .o_done(o_done)
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Observed transfers and events, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_valid) valid_cnt++;
        if (o_valid && i_ready && i_en)
            obs_q.push_back({o_addr, o_last_win, o_o_x, o_o_y});
        if (o_valid && !i_ready && i_en) stall_cyc++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic set_cfg(input int b, input int isz, input int osz,
                           input int k, input int s, input int ch,
                           input int cs);
        i_base_addr = AW'(b);
        i_i_size    = DW'(isz);
        i_o_size    = DW'(osz);
        i_k_size    = KW'(k);
        i_stride    = KW'(s);
        i_channels  = CW'(ch);
        i_ch_stride = AW'(cs);
    endtask

    task automatic push_model(input int b, input int isz, input int osz,
                              input int k, input int s, input int ch,
                              input int cs);
        beat_t e;
        for (int oy = 0; oy < osz; oy++)
            for (int ox = 0; ox < osz; ox++)
                for (int c = 0; c < ch; c++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            e.addr = AW'(b + c * cs + (oy * s + ky) * isz
                                         + ox * s + kx);
                            e.last = (c == ch - 1) && (ky == k - 1)
                                     && (kx == k - 1);
                            e.ox = DW'(ox);
                            e.oy = DW'(oy);
                            exp_q.push_back(e);
                        end
    endtask

    task automatic pulse_start();
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            @(negedge i_clk);
            t++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout o_done count %0d required %0d", tag,
                     done_cnt, d0 + 1);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_en = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d required 0", o_addr);
        end
        n_checks++;
        if ({o_valid, o_last_win, o_busy, o_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b required 0000",
                     {o_valid, o_last_win, o_busy, o_done});
        end
        n_checks++;
        if ({o_o_x, o_o_y} !== '0) begin
            n_fail++;
            $display("FAIL reset_pixel got %0d,%0d required 0,0", o_o_x, o_o_y);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        beat_t e, o;
        int d0;
        int nl = 0;
        logic [AW-1:0] first9 [9];
        first9 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        exp_q.delete();
        obs_q.delete();
        push_model(0, 5, 3, 3, 1, 1, 0);
        i_ready = 1'b1;
        d0 = done_cnt;
        set_cfg(0, 5, 3, 3, 1, 1, 0);
        pulse_start();
        wait_done(d0, 300, "basic");
        n_checks++;
        if (obs_q.size() != 81) begin
            n_fail++;
            $display("FAIL basic_count got %0d required 81", obs_q.size());
        end
        n_checks++;
        if (done_cyc - start_cyc != 82) begin
            n_fail++;
            $display("FAIL basic_done_latency got %0d required 82",
                     done_cyc - start_cyc);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_q[i].addr !== first9[i]) begin
                n_fail++;
                $display("FAIL basic_first_win[%0d] got %0d required %0d", i,
                         obs_q[i].addr, first9[i]);
            end
        end
        n_checks++;
        if (obs_q[9].addr !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_second_win got %0d required 1", obs_q[9].addr);
        end
        foreach (obs_q[i]) if (obs_q[i].last) nl++;
        n_checks++;
        if (nl != 9) begin
            n_fail++;
            $display("FAIL basic_last_win_count got %0d required 9", nl);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic_seq got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_stride_channels();
        beat_t e, o;
        int d0;
        exp_q.delete();
        obs_q.delete();
        push_model(0, 5, 2, 3, 2, 2, 25);
        d0 = done_cnt;
        set_cfg(0, 5, 2, 3, 2, 2, 25);
        pulse_start();
        wait_done(d0, 300, "stride");
        n_checks++;
        if (obs_q.size() != 72) begin
            n_fail++;
            $display("FAIL stride_count got %0d required 72", obs_q.size());
        end
        n_checks++;
        if (obs_q[9].addr !== 8'd25 || obs_q[18].addr !== 8'd2
            || obs_q[36].addr !== 8'd10) begin
            n_fail++;
            $display("FAIL stride_win_starts got %0d %0d %0d required 25 2 10",
                     obs_q[9].addr, obs_q[18].addr, obs_q[36].addr);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stride_seq got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t e, o;
        int d0;
        logic stalled = 1'b0;
        logic [AW-1:0] hold = '0;
        exp_q.delete();
        obs_q.delete();
        push_model(0, 5, 3, 3, 1, 1, 0);
        d0 = done_cnt;
        set_cfg(0, 5, 3, 3, 1, 1, 0);
        stall_cyc = 0;
        pulse_start();
        for (int t = 0; t < 800 && done_cnt == d0; t++) begin
            @(negedge i_clk);
            if (stalled) begin
                n_checks++;
                if (o_addr !== hold || o_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold got addr %0d valid %b required %0d 1",
                             o_addr, o_valid, hold);
                end
            end
            stalled = o_valid && !i_ready;
            hold = o_addr;
            @(posedge i_clk);
            #1;
            i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL bp_timeout o_done count %0d required %0d", done_cnt,
                     d0 + 1);
        end
`ifdef WINDOW_ADDR_GEN_STALL_CNT_EN
        n_checks++;
        if (o_stall_cnt !== 32'(stall_cyc)) begin
            n_fail++;
            $display("FAIL bp_stall_cnt got %0d required %0d", o_stall_cnt,
                     stall_cyc);
        end
`endif
        n_checks++;
        if (obs_q.size() != 81) begin
            n_fail++;
            $display("FAIL bp_count got %0d required 81", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL bp_seq got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_wrap_enable();
        beat_t e, o;
        int d0;
        logic [AW+2*DW+2:0] snap;
        logic [AW-1:0] wrap9 [9];
        wrap9 = '{250, 251, 252, 255, 0, 1, 4, 5, 6};
        exp_q.delete();
        obs_q.delete();
        push_model(250, 5, 1, 3, 1, 1, 0);
        d0 = done_cnt;
        set_cfg(250, 5, 1, 3, 1, 1, 0);
        pulse_start();
        for (int t = 0; t < 50 && obs_q.size() < 4; t++) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_en = 1'b0;
        snap = {o_addr, o_valid, o_last_win, o_o_x, o_o_y, o_busy};
        repeat (3) begin
            @(posedge i_clk);
            #1;
            n_checks++;
            if ({o_addr, o_valid, o_last_win, o_o_x, o_o_y, o_busy} !== snap) begin
                n_fail++;
                $display("FAIL en_freeze got %h required %h",
                         {o_addr, o_valid, o_last_win, o_o_x, o_o_y, o_busy}, snap);
            end
        end
        i_en = 1'b1;
        wait_done(d0, 100, "wrap");
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_q[i].addr !== wrap9[i]) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d] got %0d required %0d", i,
                         obs_q[i].addr, wrap9[i]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_seq got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_degenerate_ignore();
        beat_t e, o;
        int d0, v0;
        d0 = done_cnt;
        v0 = valid_cnt;
        set_cfg(0, 5, 3, 0, 1, 1, 0);
        pulse_start();
        wait_done(d0, 20, "degen");
        repeat (3) @(negedge i_clk);
        // o_done belongs to the cycle right after the start edge.
        n_checks++;
        if (done_cyc - start_cyc != 0) begin
            n_fail++;
            $display("FAIL degen_done_latency got %0d required 0",
                     done_cyc - start_cyc);
        end
        n_checks++;
        if (valid_cnt != v0) begin
            n_fail++;
            $display("FAIL degen_valid got %0d valid cycles required 0",
                     valid_cnt - v0);
        end
        exp_q.delete();
        obs_q.delete();
        push_model(0, 5, 3, 3, 1, 1, 0);
        d0 = done_cnt;
        set_cfg(0, 5, 3, 3, 1, 1, 0);
        pulse_start();
        for (int t = 0; t < 50 && obs_q.size() < 10; t++) @(negedge i_clk);
        set_cfg(100, 7, 2, 2, 2, 3, 9);
        pulse_start();
        wait_done(d0, 300, "ignore");
        n_checks++;
        if (obs_q.size() != 81) begin
            n_fail++;
            $display("FAIL ignore_count got %0d required 81", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ignore_seq got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        int d0;
        obs_q.delete();
        set_cfg(0, 5, 3, 3, 1, 1, 0);
        pulse_start();
        for (int t = 0; t < 100 && obs_q.size() < 20; t++) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        d0 = done_cnt;
        @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_addr, o_valid, o_last_win, o_o_x, o_o_y, o_busy, o_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got %h required 0",
                     {o_addr, o_valid, o_last_win, o_o_x, o_o_y, o_busy, o_done});
        end
        i_rst = 1'b0;
        repeat (100) @(negedge i_clk);
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done got %0d pulses required 0",
                     done_cnt - d0);
        end
        exp_q.delete();
        obs_q.delete();
        push_model(0, 5, 3, 3, 1, 1, 0);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, 300, "rst_restart");
        n_checks++;
        if (obs_q.size() != 81) begin
            n_fail++;
            $display("FAIL rst_restart_count got %0d required 81", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_restart_seq got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride_channels();
        test_backpressure();
        test_wrap_enable();
        test_degenerate_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
- Parametrised successor to the sequential router address generator.
- Sweeps every output pixel of a convolution layer. For each pixel it emits the SRAM read addresses of the full KxK window across all input channels.
- Supports runtime kernel size, stride, channel count and channel-plane stride, which the fixed 3x3 single-channel generator lacks.
- Sits between the layer controller and the tile-read SRAM port. Drives addresses over a valid/ready handshake so the MISO FIFO can back-pressure.

Parameters:
- ADDR_WIDTH, 8, SRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- DIM_WIDTH, 8, width of input/output feature-map size fields.
- K_WIDTH, 4, width of kernel-size and stride fields.
- CH_WIDTH, 4, width of channel-count field.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  global enable; when low all state and outputs freeze.
- i_start  in  1  one-cycle pulse; latches config and begins a sweep.
- i_base_addr  in  ADDR_WIDTH  address of channel 0, pixel (0,0).
- i_i_size  in  DIM_WIDTH  input feature-map width = height.
- i_o_size  in  DIM_WIDTH  output feature-map width = height.
- i_k_size  in  K_WIDTH  kernel width = height.
- i_stride  in  K_WIDTH  convolution stride.
- i_channels  in  CH_WIDTH  number of input channels.
- i_ch_stride  in  ADDR_WIDTH  address offset between channel planes.
- i_ready  in  1  consumer accepts o_addr this cycle.
- o_addr  out  ADDR_WIDTH  read address.
- o_valid  out  1  o_addr valid.
- o_last_win  out  1  high with the final address of each window (last c, ky, kx).
- o_o_x, o_o_y  out  DIM_WIDTH  output pixel the current address belongs to.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse at sweep end.

Behaviour:
- Reset: o_addr=0, o_valid=0, o_last_win=0, o_o_x=0, o_o_y=0, o_busy=0, o_done=0; FSM to IDLE.
- Reset mid-sweep aborts immediately. No o_done is produced.
- FSM states:
  - IDLE: on i_start&i_en, latch all config; go to RUN; o_busy=1 from the next cycle.
  - RUN: issue addresses.
  - DONE: one cycle; o_done=1, o_valid=0; return to IDLE.
- i_start is ignored outside IDLE.
- Address formula: o_addr = base + c*ch_stride + (oy*stride+ky)*i_size + (ox*stride+kx), truncated to ADDR_WIDTH. Wrap-around is silent.
- Loop order, outermost first: oy, ox, c, ky, kx. Each index runs 0..limit-1.
- Latency: start sampled at edge N gives o_valid=1 with the first address after edge N+1.
- Handshake:
  - A transfer is o_valid & i_ready & i_en.
  - o_addr, o_o_x, o_o_y and o_last_win advance only on a transfer.
  - While stalled, all outputs hold stable. o_valid never drops while RUN has addresses left.
- Completion: the cycle after the final transfer, o_valid=0 and o_done=1 (DONE state).
- Degenerate config: any of k_size, stride, o_size, channels equal to 0 at start goes IDLE -> DONE with no valid addresses. o_done still pulses.
- Bounds: no bounds check against i_i_size; the layer controller guarantees (o_size-1)*stride+k_size <= i_size.
- Address generation uses incremental adders only; no multipliers in the per-cycle path.
  - Row/channel/window base registers are updated on loop wrap.
  - A transfer is sustainable every cycle.

Optional Feature:
- Macro: WINDOW_ADDR_GEN_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt [31:0], counting cycles with o_valid & ~i_ready & i_en.
  - Cleared on reset and on accepted i_start; saturates at all-ones.
- Undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Package window_addr_gen_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a packed config struct (base, i_size, o_size, k_size, stride, channels, ch_stride);
  - the DONE pulse length constant.
- One sub-module, wag_loop_cnt: a single-level counter with limit, increment enable, and a wrap output. It is instantiated five times and chained through wrap outputs.

Test Plan:
- Basic sweep: base=0, i_size=5, o_size=3, k=3, stride=1, ch=1, ready=1.
  - First 9 addresses are 0,1,2,5,6,7,10,11,12; second window starts at 1.
  - 81 transfers total; o_last_win high on every 9th transfer.
  - o_done high exactly 82 cycles after the start edge.
- Stride/channels: i_size=5, o_size=2, k=3, stride=2, ch=2, ch_stride=25.
  - Window (0,0) is 0..12 pattern, then 25,26,27,30,... .
  - Window (1,0) starts at 2; window (0,1) starts at 10; 72 transfers.
- Backpressure: toggle i_ready pseudo-randomly.
  - o_addr and o_valid hold during stalls; the address sequence matches the basic sweep.
  - With the macro defined, o_stall_cnt equals the number of stall cycles.
- Wrap and enable: base=250, i_size=5, k=3, o_size=1.
  - Addresses are 250,251,252,255,0,1,4,5,6.
  - Dropping i_en for 3 cycles mid-window freezes all outputs.
- Degenerate and ignore: start with k_size=0 gives o_done one cycle after the start edge and o_valid never high. i_start during RUN is ignored.
- Reset mid-sweep: assert i_rst after 20 transfers.
  - All outputs read 0 the next cycle and no o_done is produced.
  - A fresh start then reproduces the basic sweep.
